// File: rtl/bc_pkg.sv
// bc_pkg: shared FSM states and sizing for the barcode receiver.
package bc_pkg;
    typedef enum logic [2:0] {IDLE, START, WAIT_FALL, BIT, DONE} bc_state_t;
    localparam int ID_BITS = 8;
    localparam int TMR_W_DEF = 22;
endpackage

// File: rtl/bc_sync.sv
// bc_sync: 2-flop synchronizer for the barcode line plus falling-edge detector.
module bc_sync (
    input  logic clk,
    input  logic rst,
    input  logic BC,
    output logic bc_s,
    output logic fall
);
    logic meta_q, sync_q, prev_q;
    always_ff @(posedge clk)
        if (rst) {meta_q, sync_q, prev_q} <= 3'b111;
        else {meta_q, sync_q, prev_q} <= {BC, meta_q, sync_q};
    assign bc_s = sync_q;
    assign fall = prev_q & ~sync_q;
endmodule

// File: rtl/barcode_rx.sv
// barcode_rx: self-clocked serial barcode decoder producing ID/ID_vld.
// Optional BC_ID_FILTER_EN: accept only frames whose top two bits are 00.
module barcode_rx import bc_pkg::*; #(
    parameter int TMR_W = TMR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               BC,
    input  logic               clr_ID_vld,
    output logic [ID_BITS-1:0] ID,
    output logic               ID_vld
);
    logic bc_s, fall, sample, accept;
    bc_state_t state_q, state_d;
    logic [TMR_W-1:0] period_q, period_d, bit_tmr_q, bit_tmr_d;
    logic [ID_BITS-1:0] shift_q, shift_d, id_q, id_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic vld_q, vld_d;
    bc_sync u_sync (.clk(clk), .rst(rst), .BC(BC), .bc_s(bc_s), .fall(fall));
    assign sample = state_q == BIT && bit_tmr_q == period_q;
`ifdef BC_ID_FILTER_EN
    assign accept = state_q == DONE && shift_q[ID_BITS-1:ID_BITS-2] == 2'b00;
`else
    assign accept = state_q == DONE;
`endif
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        bit_tmr_d = bit_tmr_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (fall) begin
                    period_d = '0;
                    state_d  = START;
                end
            end
            START:
                if (!bc_s) period_d = &period_q ? period_q : period_q + 1'b1;
                else state_d = WAIT_FALL;
            WAIT_FALL:
                if (fall) begin
                    bit_tmr_d = '0;
                    state_d   = BIT;
                end
            BIT: begin
                bit_tmr_d = bit_tmr_q + 1'b1;
                if (sample) begin
                    shift_d   = {shift_q[ID_BITS-2:0], bc_s};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = &bit_cnt_q ? DONE : WAIT_FALL;
                end
            end
            default: state_d = IDLE;
        endcase
        id_d  = accept ? shift_q : id_q;
        vld_d = accept | (vld_q & ~clr_ID_vld);
    end
    always_ff @(posedge clk)
        if (rst) begin
            state_q   <= IDLE;
            period_q  <= '0;
            bit_tmr_q <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            id_q      <= '0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            bit_tmr_q <= bit_tmr_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            id_q      <= id_d;
            vld_q     <= vld_d;
        end
    assign ID = id_q;
    assign ID_vld = vld_q;
endmodule

// File: tb/tb_barcode_rx.sv
// tb_barcode_rx: drives encoded barcode frames and checks ID/ID_vld against a frame-level model.
module tb_barcode_rx;
    logic clk = 1'b0, rst = 1'b1, BC = 1'b1, clr_ID_vld = 1'b0;
    logic [7:0] ID;
    logic ID_vld;
    int n_cmp = 0, n_bad = 0;
    logic [7:0] exp_id = 8'h00;
    logic exp_vld = 1'b0;

    barcode_rx dut (.clk(clk), .rst(rst), .BC(BC), .clr_ID_vld(clr_ID_vld), .ID(ID), .ID_vld(ID_vld));

    always #5 clk = ~clk;

    function automatic bit acc(input logic [7:0] v);
`ifdef BC_ID_FILTER_EN
        return v[7:6] == 2'b00;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    task automatic pulse_clr();
        clr_ID_vld = 1'b1;
        @(posedge clk); #1;
        clr_ID_vld = 1'b0;
        exp_vld = 1'b0;
        chk("clr_vld", {7'b0, ID_vld}, {7'b0, exp_vld});
        chk("clr_id", ID, exp_id);
    endtask

    // mode: 0 plain, 1 check ID_vld rise latency, 2 clr during acceptance, 3 ID_vld held high
    task automatic send(input logic [7:0] v, input int p, input int mode, input int nbits);
        bit w[$];
        int lf, n1, n0;
        n1 = (p / 2 < 1) ? 1 : p / 2;
        n0 = p + p / 2;
        lf = 0;
        repeat (p) w.push_back(1'b0);
        repeat (p) w.push_back(1'b1);
        for (int b = 0; b < nbits; b++) begin
            int lo = v[7-b] ? n1 : n0;
            lf = w.size();
            repeat (lo) w.push_back(1'b0);
            repeat (2 * p - lo) w.push_back(1'b1);
        end
        for (int i = 0; i < w.size() + p + 10; i++) begin
            @(posedge clk); #1;
            if (nbits == 8 && mode == 1 && i == lf + p + 3)
                chk("lat_before", {7'b0, ID_vld}, {7'b0, exp_vld});
            if (nbits == 8 && mode == 1 && i == lf + p + 4)
                chk("lat_after", {7'b0, ID_vld}, acc(v) ? 8'h01 : {7'b0, exp_vld});
            if (mode == 3 && i <= lf + p + 4)
                chk("hold_vld", {7'b0, ID_vld}, 8'h01);
            if (mode == 2) clr_ID_vld = (i == lf + p + 3);
            BC = (i < w.size()) ? w[i] : 1'b1;
        end
        clr_ID_vld = 1'b0;
        if (nbits == 8) begin
            if (acc(v)) begin
                exp_id = v;
                exp_vld = 1'b1;
            end
            chk($sformatf("id_%h", v), ID, exp_id);
            chk($sformatf("vld_%h", v), {7'b0, ID_vld}, {7'b0, exp_vld});
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_id", ID, 8'h00);
        chk("rst_vld", {7'b0, ID_vld}, 8'h00);
        rst = 1'b0;
        send(8'h15, 50, 1, 8);
        pulse_clr();
        send(8'hC3, 20, 0, 8);
        pulse_clr();
        send(8'h05, 30, 0, 8);
        send(8'h2A, 30, 3, 8);
        send(8'h0C, 12, 2, 8);
        send(8'h3F, 16, 0, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_id = 8'h00;
        exp_vld = 1'b0;
        chk("midrst_id", ID, exp_id);
        chk("midrst_vld", {7'b0, ID_vld}, 8'h00);
        send(8'h11, 10, 1, 8);
        send(8'h00, 2000, 0, 8);
        pulse_clr();
        send(8'h3E, 2, 1, 8);
        for (int k = 0; k < 10; k++) begin
            logic [7:0] v;
            int p;
            v = 8'($urandom);
            p = int'($urandom_range(2, 40));
            if ($urandom_range(0, 1) == 1) pulse_clr();
            send(v, p, 0, 8);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
